// File: rtl/mem_host_initiator.sv
// mem_host_initiator
//
// Host-side initiator for the SRAM memory controller user port. Takes one
// command at a time from a valid/ready stream and turns it into a single bus
// cycle on ADDR/CE/CSB/WEB/OEB/IDATA. For reads it samples ODATA a fixed
// RD_LAT cycles after the bus-active cycle and returns the byte with a
// one-cycle RSP_VALID pulse. Traffic is held off while BIST_EN is high and
// for a recovery window after it falls, so that BISR repair can finish.
//
// Handshake: a command transfers on a rising edge where CMD_VALID && CMD_READY.
// CMD_READY depends only on registered state and BIST_EN, never on CMD_VALID.
// RSP_VALID is a one-cycle pulse with no back-pressure; RSP_RDATA holds its
// value until the next capture.
//
// Ports:
//   CLK, RSTN            clock (rising edge), synchronous active-low reset
//   CMD_VALID/READY      command handshake
//   CMD_WR/ADDR/WDATA    1 = write; address {bank[15:10], word[9:0]}; data
//   RSP_VALID/RDATA      read response pulse and held read data
//   BIST_EN              BIST running; blocks and aborts traffic
//   ADDR/CE/CSB/WEB/OEB  registered controller bus (CSB/WEB/OEB active-low)
//   IDATA / ODATA        write data to controller / read data from array
//   WR_CNT, RD_CNT       (only with MEM_HOST_CNT_EN) saturating counts of
//                        write bus cycles and read response pulses
//
// Parameters:
//   RD_LAT       bus-active cycle to ODATA sample edge, bus cycle counts as 1 (2..15)
//   RECOVER_CYC  recovery length after BIST_EN falls (1..255)
//
// Optional feature macro: MEM_HOST_CNT_EN
module mem_host_initiator #(
    parameter int unsigned RD_LAT      = 3,
    parameter int unsigned RECOVER_CYC = 8
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WR,
    input  logic [15:0] CMD_ADDR,
    input  logic [7:0]  CMD_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    input  logic        BIST_EN,
    output logic [15:0] ADDR,
    output logic        CE,
    output logic        CSB,
    output logic        WEB,
    output logic        OEB,
    output logic [7:0]  IDATA,
    input  logic [7:0]  ODATA
`ifdef MEM_HOST_CNT_EN
    ,
    output logic [15:0] WR_CNT,
    output logic [15:0] RD_CNT
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        BLOCKED,
        RECOVER
    } state_t;

    localparam logic [7:0] RD_LAT_INIT  = 8'(RD_LAT - 1);
    localparam logic [7:0] RECOVER_INIT = 8'(RECOVER_CYC);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  idata_q, idata_d;
    logic        ce_q, ce_d;
    logic        csb_q, csb_d;
    logic        web_q, web_d;
    logic        oeb_q, oeb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        idata_d     = idata_q;
        // Bus defaults to idle every cycle; only an accepted command drives it.
        ce_d        = 1'b0;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        oeb_d       = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            IDLE: begin
                if (BIST_EN) begin
                    state_d = BLOCKED;
                end else if (CMD_VALID) begin
                    // The bus registers load here so the access appears in
                    // the ISSUE cycle itself.
                    state_d = ISSUE;
                    wr_d    = CMD_WR;
                    addr_d  = CMD_ADDR;
                    ce_d    = 1'b1;
                    csb_d   = 1'b0;
                    web_d   = ~CMD_WR;
                    oeb_d   = CMD_WR;
                    if (CMD_WR) begin
                        idata_d = CMD_WDATA;
                    end
                end
            end
            ISSUE: begin
                if (BIST_EN) begin
                    state_d = BLOCKED;
                    cnt_d   = 8'd0;
                end else if (wr_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_RD;
                    cnt_d   = RD_LAT_INIT;
                end
            end
            WAIT_RD: begin
                if (BIST_EN) begin
                    state_d = BLOCKED;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'd1) begin
                    // Last wait cycle: ODATA is valid at this edge.
                    state_d     = IDLE;
                    cnt_d       = 8'd0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ODATA;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            BLOCKED: begin
                if (!BIST_EN) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_INIT;
                end
            end
            RECOVER: begin
                if (BIST_EN) begin
                    state_d = BLOCKED;
                    cnt_d   = 8'd0;
                end else if (cnt_q <= 8'd1) begin
                    // Counter reaches 0 on the edge that returns to IDLE.
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            wr_q        <= 1'b0;
            addr_q      <= 16'd0;
            idata_q     <= 8'd0;
            ce_q        <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            idata_q     <= idata_d;
            ce_q        <= ce_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign CMD_READY = (state_q == IDLE) && !BIST_EN;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign ADDR      = addr_q;
    assign CE        = ce_q;
    assign CSB       = csb_q;
    assign WEB       = web_q;
    assign OEB       = oeb_q;
    assign IDATA     = idata_q;

`ifdef MEM_HOST_CNT_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;

    // Writes count on their bus cycle; reads count only when a response is
    // delivered, so aborted reads never reach RD_CNT.
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if ((state_q == ISSUE) && wr_q && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (rsp_valid_q && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign WR_CNT = wr_cnt_q;
    assign RD_CNT = rd_cnt_q;
`endif

endmodule

// File: doc/mem_host_initiator.md
Name: mem_host_initiator

Overview:
- Host-side initiator for the SRAM memory controller: drives its user port (ADDR/CE/CSB/WEB/OEB/IDATA) and collects read data from the controller's ODATA return path.
- Converts a valid/ready command stream (read/write, 16-bit address, 8-bit data) into single-cycle bus accesses, with a fixed-latency read capture.
- Holds off all traffic while BIST runs, and for a recovery window afterwards so BISR repair can finish.

Parameters:
- RD_LAT, 3, cycles from the bus-active cycle to the ODATA sample edge, counting the bus-active cycle as 1; legal range 2..15.
- RECOVER_CYC, 8, idle cycles after BIST_EN falls before new commands are accepted; legal range 1..255.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RSTN  in  1  reset, synchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when VALID && READY.
- CMD_WR  in  1  1 = write, 0 = read.
- CMD_ADDR  in  16  [15:10] = bank, [9:0] = word.
- CMD_WDATA  in  8  write data.
- RSP_VALID  out  1  one-cycle pulse marking read data.
- RSP_RDATA  out  8  captured read data; held until the next capture.
- BIST_EN  in  1  BIST active; blocks traffic.
- ADDR  out  16  to controller ADDR.
- CE  out  1  to controller CE.
- CSB  out  1  to controller CSB, active-low.
- WEB  out  1  to controller WEB, active-low write.
- OEB  out  1  to controller OEB, active-low read.
- IDATA  out  8  to controller IDATA.
- ODATA  in  8  read data returned from the memory array.

Behaviour:
- Reset (RSTN=0 at an edge):
  - state=IDLE; ADDR=0, IDATA=0, CE=0, CSB=1, WEB=1, OEB=1.
  - RSP_VALID=0, RSP_RDATA=0; latency and recovery counters = 0.
  - Reset mid-operation abandons any access: no RSP_VALID, bus idle.
- CMD_READY = (state==IDLE) && !BIST_EN. This is combinational from registered state; CMD_READY=1 in the cycle after reset when BIST_EN=0.
- Bus outputs are registered.
  - Idle bus: CE=0, CSB=1, WEB=1, OEB=1. ADDR/IDATA hold their last values.
- States: IDLE, ISSUE, WAIT_RD, BLOCKED, RECOVER.
- IDLE:
  - BIST_EN=1 -> BLOCKED.
  - Else if CMD_VALID -> ISSUE, latching CMD_WR, CMD_ADDR and CMD_WDATA.
- ISSUE (exactly one cycle on the bus):
  - CE=1, CSB=0, ADDR=latched addr.
  - Write: WEB=0, OEB=1, IDATA=wdata.
  - Read: WEB=1, OEB=0.
  - Next state: write -> IDLE; read -> WAIT_RD with counter = RD_LAT-1.
- WAIT_RD:
  - Bus idle; counter decrements each cycle.
  - At counter==1, ODATA is sampled into RSP_RDATA at that edge. RSP_VALID=1 in the following cycle, which is also an IDLE cycle.
- Timing, with acceptance in cycle N:
  - Bus active in N+1.
  - Writes: next accept possible in N+2 (one write per 2 cycles).
  - Reads: ODATA sampled at the end of cycle N+RD_LAT; RSP_VALID in N+RD_LAT+1, overlapping with a new acceptance.
- BIST_EN rising in ISSUE or WAIT_RD:
  - Access aborted; bus forced idle at the next edge; no RSP_VALID; -> BLOCKED.
  - BIST_EN has priority over a same-cycle CMD_VALID in IDLE.
- BLOCKED: bus idle; BIST_EN=0 -> RECOVER with counter = RECOVER_CYC.
- RECOVER:
  - Counter decrements; at 0 -> IDLE.
  - BIST_EN=1 again -> BLOCKED and the counter is discarded.
- RSP_VALID is never high for a write, nor for two consecutive cycles from a single read.

Optional Feature:
- Macro MEM_HOST_CNT_EN.
- When defined, two extra outputs are added:
  - WR_CNT[15:0]: increments on each write ISSUE cycle.
  - RD_CNT[15:0]: increments on each RSP_VALID pulse.
  - Both saturate at 16'hFFFF and reset to 0 on RSTN=0. Aborted reads are not counted.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then write: release RSTN with BIST_EN=0; issue write addr 16'h0C05, data 8'hA5 -> next cycle CE=1, CSB=0, WEB=0, OEB=1, ADDR=16'h0C05, IDATA=8'hA5; following cycle bus idle and CMD_READY=1.
- Read latency (RD_LAT=3): read 16'h0C05 accepted in cycle 0; ODATA=8'h5A during cycle 3 -> RSP_VALID=1 and RSP_RDATA=8'h5A in cycle 4 only; CMD_READY=1 in cycle 2? No: CMD_READY=0 in cycles 1-3, =1 in cycle 4.
- Back-to-back: CMD_VALID held for 4 writes -> bus-active cycles spaced exactly 2 apart; CSB=1 between them.
- BIST abort: BIST_EN rises during WAIT_RD -> no RSP_VALID, bus idle, CMD_READY=0; BIST_EN falls -> CMD_READY returns exactly RECOVER_CYC+1 cycles later (9 at default).
- Reset mid-read: RSTN=0 in WAIT_RD -> all outputs at reset values next edge; no RSP_VALID after release.
- MEM_HOST_CNT_EN defined: 3 writes, 2 reads, 1 aborted read -> WR_CNT=3, RD_CNT=2.
